coord_dispatcher: RTL and testbench
===================================

// Module: coord_dispatcher
// PURPOSE
//  Coordinate generator/result collector for the Mandelbrot engine array. Scans the screen in
//  raster order and hands each pixel {x,y,re,im} to a free engine over the shared latch bus
//  (engine_addr/in_word/latch_en). Services engine result requests over service_req/req_ack,
//  captures the shared 27-bit out_word bus and writes the iteration count to the frame buffer.
// PARAMETERS
//  N_ENGINES  16   engines attached; must be <= 2**(`E_ADDR_WIDTH+1)
//  H_RES      640  pixels per line (x fits 10 bits)
//  V_RES      480  lines per frame (y fits 9 bits)
// PORTS
//  Engine_CLK   in   1                  single clock, all logic on rising edge
//  eRST         in   1                  synchronous, active-high reset
//  start        in   1                  1-cycle pulse: begin frame (ignored while busy)
//  re_min       in   32                 Q8.24 real coordinate of x=0, sampled on start
//  im_max       in   32                 Q8.24 imag coordinate of y=0, sampled on start
//  step         in   32                 Q8.24 per-pixel increment, sampled on start
//  available    in   N_ENGINES          per-engine free flag
//  service_req  in   N_ENGINES          per-engine result-ready flag
//  out_word     in   27                 shared result bus {x[9:0],y[8:0],iter[7:0]}
//  engine_addr  out  `E_ADDR_WIDTH+1    target engine of latch_en
//  in_word      out  83                 {x[9:0],y[8:0],re[31:0],im[31:0]}
//  latch_en     out  1                  1-cycle dispatch strobe
//  req_ack      out  N_ENGINES          one-hot grant enabling that engine onto out_word
//  fb_we        out  1                  frame-buffer write strobe
//  fb_addr      out  19                 y*H_RES + x
//  fb_data      out  8                  iteration count
//  busy         out  1                  frame in progress
//  frame_done   out  1                  1-cycle pulse when last result written
// BEHAVIOUR
//  Reset: all outputs 0; scan x=y=0; outstanding=0; both FSMs idle; rr pointer=0. Reset mid-frame
//   abandons the frame (engines share eRST and return to free).
//  Coordinates: re = re_min + x*step, im = im_max - y*step, built incrementally (add step per x,
//   reload re_min and subtract step per line); 32-bit two's complement, wrap silently.
//  Dispatch FSM: D_IDLE -start-> D_SEARCH (busy=1). D_SEARCH: if pixels remain and any
//   available bit set, pick lowest index, drive engine_addr/in_word, latch_en=1 for exactly one
//   cycle (D_LATCH), outstanding+1, advance x (wrap to 0 with y+1 at H_RES). D_LATCH -> D_GAP:
//   one cycle latch_en=0 so the engine's available has fallen before the next search.
//   D_GAP -> D_SEARCH. Dispatch of a pixel is never repeated or skipped.
//  Collect FSM (runs concurrently): C_IDLE: if any service_req, grant round-robin starting at
//   rr pointer; req_ack[i]=1 -> C_ACK. C_ACK: first cycle capture out_word, fb_we=1 next cycle
//   with fb_addr=y*H_RES+x, fb_data=iter; hold req_ack until service_req[i]=0 -> C_REL.
//   C_REL: req_ack=0, rr=i+1 mod N_ENGINES, outstanding-1 -> C_IDLE. At most one req_ack bit.
//  Simultaneous dispatch + collect: outstanding nets to unchanged. latch_en may assert while an
//   engine holds req_ack; engines tolerate this (they wait for both low).
//  Frame end: all H_RES*V_RES pixels dispatched and outstanding==0 -> frame_done pulse, busy=0,
//   D_IDLE. start during busy ignored. No available engine -> D_SEARCH stalls indefinitely.
// TESTING
//  1) N_ENGINES=2, H_RES=4,V_RES=2, re_min=-2.0 (0xFE000000), step=0.5, models return iter=x+y
//     -> 8 fb writes, fb_addr 0..7 each once, fb_data correct, frame_done once.
//  2) Dispatch check: pixel (3,0) in_word re=0xFF800000; next pixel (0,1) im=im_max-step.
//  3) All available=0 for 50 cycles -> latch_en stays 0; release engine 5 -> engine_addr=5 latched.
//  4) service_req on engines 1,3 same cycle, rr=2 -> engine 3 acked first, then 1; never both.
//  5) Engine holds service_req 4 cycles after ack -> req_ack held 4 cycles, single fb_we.
//  6) eRST mid-frame (outstanding=3) -> all outputs 0 next cycle; new start restarts at (0,0).

Source files
------------

// File: rtl/coord_dispatcher.sv
// Mandelbrot coordinate dispatcher and result collector.
// Ports: Engine_CLK/eRST, start + re_min/im_max/step frame setup,
//   available/latch_en/engine_addr/in_word for dispatch,
//   service_req/req_ack/out_word for collect, fb_* writes,
//   busy/frame_done status.
`ifndef E_ADDR_WIDTH
`define E_ADDR_WIDTH 3
`endif

module coord_dispatcher #(
  parameter int N_ENGINES = 16,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic                   Engine_CLK,
  input  logic                   eRST,
  input  logic                   start,
  input  logic [31:0]            re_min,
  input  logic [31:0]            im_max,
  input  logic [31:0]            step,
  input  logic [N_ENGINES-1:0]   available,
  input  logic [N_ENGINES-1:0]   service_req,
  input  logic [26:0]            out_word,
  output logic [`E_ADDR_WIDTH:0] engine_addr,
  output logic [82:0]            in_word,
  output logic                   latch_en,
  output logic [N_ENGINES-1:0]   req_ack,
  output logic                   fb_we,
  output logic [18:0]            fb_addr,
  output logic [7:0]             fb_data,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int AW = `E_ADDR_WIDTH + 1;
  localparam int RW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam int OW = $clog2(N_ENGINES + 1) + 1;

  typedef enum logic [1:0] {
    D_IDLE,
    D_SEARCH,
    D_LATCH,
    D_GAP
  } d_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_ACK,
    C_REL
  } c_state_t;

  d_state_t d_state, d_next;
  c_state_t c_state, c_next;

  logic [9:0]    x;
  logic [8:0]    y;
  logic          all_disp;
  logic [31:0]   re_acc;
  logic [31:0]   im_acc;
  logic [31:0]   re_min_r;
  logic [31:0]   step_r;
  logic [OW-1:0] outstanding;

  logic [RW-1:0] rr;
  logic [RW-1:0] sel_r;
  logic          ack_first;

  logic          d_start;
  logic          d_fire;
  logic          d_done;
  logic          c_grant;
  logic          c_cap;
  logic          c_leave;
  logic          c_rel;
  logic          dec;

  logic          avail_any;
  logic [AW-1:0] avail_idx;
  logic          gnt_hit;
  logic [RW-1:0] gnt_idx;
  int            scan;

  // lowest-index free engine
  always_comb begin
    avail_any = |available;
    avail_idx = '0;
    for (int i = N_ENGINES - 1; i >= 0; i--) begin
      if (available[i]) avail_idx = AW'(i);
    end
  end

  // round-robin scan starting at rr
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    scan    = 0;
    for (int k = 0; k < N_ENGINES; k++) begin
      scan = int'(rr) + k;
      if (scan >= N_ENGINES) scan = scan - N_ENGINES;
      if (!gnt_hit && service_req[RW'(scan)]) begin
        gnt_hit = 1'b1;
        gnt_idx = RW'(scan);
      end
    end
  end

  always_ff @(posedge Engine_CLK) begin
    if (eRST) begin
      d_state <= D_IDLE;
      c_state <= C_IDLE;
    end else begin
      d_state <= d_next;
      c_state <= c_next;
    end
  end

  always_comb begin
    d_next  = d_state;
    d_start = 1'b0;
    d_fire  = 1'b0;
    d_done  = 1'b0;
    unique case (d_state)
      D_IDLE: begin
        if (start) begin
          d_start = 1'b1;
          d_next  = D_SEARCH;
        end
      end
      D_SEARCH: begin
        if (!all_disp && avail_any) begin
          d_fire = 1'b1;
          d_next = D_LATCH;
        end else if (all_disp && outstanding == '0) begin
          d_done = 1'b1;
          d_next = D_IDLE;
        end
      end
      D_LATCH: d_next = D_GAP;
      D_GAP:   d_next = D_SEARCH;
      default: d_next = D_IDLE;
    endcase
  end

  always_comb begin
    c_next  = c_state;
    c_grant = 1'b0;
    c_cap   = 1'b0;
    c_leave = 1'b0;
    c_rel   = 1'b0;
    unique case (c_state)
      C_IDLE: begin
        if (gnt_hit) begin
          c_grant = 1'b1;
          c_next  = C_ACK;
        end
      end
      C_ACK: begin
        c_cap = ack_first;
        if (!service_req[sel_r]) begin
          c_leave = 1'b1;
          c_next  = C_REL;
        end
      end
      C_REL: begin
        c_rel  = 1'b1;
        c_next = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  // stray releases outside a frame never drive the count negative
  assign dec = c_rel && (outstanding != '0);

  always_ff @(posedge Engine_CLK) begin
    if (eRST) begin
      engine_addr <= '0;
      in_word     <= '0;
      latch_en    <= 1'b0;
      req_ack     <= '0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      x           <= '0;
      y           <= '0;
      all_disp    <= 1'b0;
      re_acc      <= '0;
      im_acc      <= '0;
      re_min_r    <= '0;
      step_r      <= '0;
      outstanding <= '0;
      rr          <= '0;
      sel_r       <= '0;
      ack_first   <= 1'b0;
    end else begin
      latch_en   <= 1'b0;
      frame_done <= 1'b0;
      fb_we      <= 1'b0;

      if (d_start) begin
        busy     <= 1'b1;
        x        <= '0;
        y        <= '0;
        all_disp <= 1'b0;
        re_min_r <= re_min;
        step_r   <= step;
        re_acc   <= re_min;
        im_acc   <= im_max;
      end

      if (d_fire) begin
        latch_en    <= 1'b1;
        engine_addr <= avail_idx;
        in_word     <= {x, y, re_acc, im_acc};
        if (x == 10'(H_RES - 1)) begin
          x      <= '0;
          re_acc <= re_min_r;
          im_acc <= im_acc - step_r;
          if (y == 9'(V_RES - 1)) all_disp <= 1'b1;
          else y <= y + 1'b1;
        end else begin
          x      <= x + 1'b1;
          re_acc <= re_acc + step_r;
        end
      end

      if (d_done) begin
        busy       <= 1'b0;
        frame_done <= 1'b1;
      end

      unique case ({d_fire, dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if (c_grant) begin
        req_ack   <= N_ENGINES'(1) << gnt_idx;
        sel_r     <= gnt_idx;
        ack_first <= 1'b1;
      end

      // out_word is valid the cycle after req_ack rises
      if (c_cap) begin
        ack_first <= 1'b0;
        fb_we     <= 1'b1;
        fb_addr   <= 19'(out_word[16:8]) * 19'(H_RES)
                   + 19'(out_word[26:17]);
        fb_data   <= out_word[7:0];
      end

      if (c_leave) req_ack <= '0;

      if (c_rel) begin
        rr <= (int'(sel_r) == N_ENGINES - 1) ? '0 : sel_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coord_dispatcher.sv
// Self-checking bench for coord_dispatcher with a
// behavioural engine-array model and raster reference.
`ifndef E_ADDR_WIDTH
`define E_ADDR_WIDTH 3
`endif

module tb_coord_dispatcher;

  localparam int N    = 8;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int AW   = `E_ADDR_WIDTH + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   re_min;
  logic [31:0]   im_max;
  logic [31:0]   step;
  logic [N-1:0]  available;
  logic [N-1:0]  service_req;
  logic [26:0]   out_word;
  logic [AW-1:0] engine_addr;
  logic [82:0]   in_word;
  logic          latch_en;
  logic [N-1:0]  req_ack;
  logic          fb_we;
  logic [18:0]   fb_addr;
  logic [7:0]    fb_data;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  int          e_st  [N];
  int          e_cnt [N];
  int          e_ack [N];
  int          e_hold[N];
  logic [26:0] e_res [N];
  logic [N-1:0] eng_mask;
  int          lat_max;
  int          lat_fix;
  logic [7:0]  salt;

  coord_dispatcher #(
    .N_ENGINES(N),
    .H_RES(H),
    .V_RES(V)
  ) dut (
    .Engine_CLK(clk),
    .eRST(rst),
    .start(start),
    .re_min(re_min),
    .im_max(im_max),
    .step(step),
    .available(available),
    .service_req(service_req),
    .out_word(out_word),
    .engine_addr(engine_addr),
    .in_word(in_word),
    .latch_en(latch_en),
    .req_ack(req_ack),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic engine_reset();
    for (int e = 0; e < N; e++) begin
      e_st[e] = 0;
      e_res[e] = '0;
    end
    available   = eng_mask;
    service_req = '0;
    out_word    = '0;
  endtask

  // one negedge step of the engine array
  task automatic engine_step();
    logic [26:0] ow;
    logic [9:0]  px;
    logic [8:0]  py;
    int          t;
    ow = '0;
    for (int e = 0; e < N; e++) begin
      case (e_st[e])
        0: if (latch_en && int'(engine_addr) == e) begin
          px = in_word[82:73];
          py = in_word[72:64];
          t  = int'(px) + int'(py) + int'(salt);
          e_res[e]  = {px, py, t[7:0]};
          e_cnt[e]  = (lat_fix > 0) ? lat_fix
                                    : $urandom_range(1, lat_max);
          e_ack[e]  = 0;
          e_hold[e] = $urandom_range(1, 3);
          available[e] = 1'b0;
          e_st[e] = 1;
        end
        1: begin
          e_cnt[e]--;
          if (e_cnt[e] == 0) begin
            service_req[e] = 1'b1;
            e_st[e] = 2;
          end
        end
        2: if (req_ack[e]) begin
          e_ack[e]++;
          if (e_ack[e] >= e_hold[e]) begin
            service_req[e] = 1'b0;
            e_st[e] = 3;
          end
        end
        3: if (!req_ack[e]) begin
          available[e] = 1'b1;
          e_st[e] = 0;
        end
        default: e_st[e] = 0;
      endcase
      if (req_ack[e]) ow = ow | e_res[e];
    end
    out_word = ow;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    engine_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [131:0] outs;
    rst = 1'b1;
    start = 1'b0;
    eng_mask = '0;
    engine_reset();
    re_min = '0;
    im_max = '0;
    step = '0;
    repeat (3) @(negedge clk);
    outs = {engine_addr, in_word, latch_en, req_ack, fb_we,
            fb_addr, fb_data, busy, frame_done};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || latch_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b latch=%b want 0 0",
               busy, latch_en);
    end
  endtask

  task automatic test_frame(input logic [N-1:0] mask,
                            input logic [31:0] rmin,
                            input logic [31:0] imax,
                            input logic [31:0] stp,
                            input logic [7:0] slt,
                            input bit spec_chk,
                            input int lmax);
    bit          seen[NPIX];
    int          n_disp, n_wr, n_done, n_seen, multi;
    int          done_cyc, ex, ey, exp_a, cyc;
    bit          finished;
    logic [82:0] exp_w;
    logic [31:0] ere, eim;
    logic [7:0]  ed;
    int          t;
    eng_mask = mask;
    lat_max = lmax;
    lat_fix = 0;
    salt = slt;
    engine_reset();
    re_min = rmin;
    im_max = imax;
    step = stp;
    n_disp = 0; n_wr = 0; n_done = 0; multi = 0;
    finished = 0; done_cyc = 0;
    for (int i = 0; i < NPIX; i++) seen[i] = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL frame_busy got %b want 1", busy);
        end
      end
      if (req_ack !== '0 && !$onehot(req_ack)) multi++;
      if (latch_en) begin
        exp_a = -1;
        for (int e = N - 1; e >= 0; e--)
          if (available[e]) exp_a = e;
        checks++;
        if (int'(engine_addr) !== exp_a) begin
          errors++;
          $display("FAIL dispatch_addr got %0d want %0d",
                   engine_addr, exp_a);
        end
        ex  = n_disp % H;
        ey  = n_disp / H;
        ere = rmin + 32'(ex) * stp;
        eim = imax - 32'(ey) * stp;
        exp_w = {10'(ex), 9'(ey), ere, eim};
        checks++;
        if (n_disp >= NPIX || in_word !== exp_w) begin
          errors++;
          $display("FAIL dispatch_word n=%0d got %h want %h",
                   n_disp, in_word, exp_w);
        end
        if (spec_chk && ex == 3 && ey == 0) begin
          checks++;
          if (in_word[63:32] !== 32'hFF800000) begin
            errors++;
            $display("FAIL re_3_0 got %h want ff800000",
                     in_word[63:32]);
          end
        end
        if (spec_chk && ex == 0 && ey == 1) begin
          checks++;
          if (in_word[31:0] !== imax - stp) begin
            errors++;
            $display("FAIL im_0_1 got %h want %h",
                     in_word[31:0], imax - stp);
          end
        end
        n_disp++;
      end
      if (fb_we) begin
        checks++;
        if (int'(fb_addr) >= NPIX) begin
          errors++;
          $display("FAIL fb_addr_range got %0d want <%0d",
                   fb_addr, NPIX);
        end else begin
          t  = int'(fb_addr) % H + int'(fb_addr) / H + int'(slt);
          ed = t[7:0];
          if (seen[int'(fb_addr)] || fb_data !== ed) begin
            errors++;
            $display("FAIL fb_write addr=%0d dup=%0d got %h want %h",
                     fb_addr, seen[int'(fb_addr)], fb_data, ed);
          end
          seen[int'(fb_addr)] = 1;
        end
        n_wr++;
      end
      if (frame_done) begin
        n_done++;
        checks++;
        if (n_wr !== NPIX) begin
          errors++;
          $display("FAIL done_early writes=%0d want %0d", n_wr, NPIX);
        end
        if (!finished) done_cyc = cyc;
        finished = 1;
      end
      if (finished && cyc >= done_cyc + 6) break;
      engine_step();
      start = (cyc == 0 || cyc == 6);
    end
    start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL frame_timeout done=%0d want 1", n_done);
    end
    n_seen = 0;
    for (int i = 0; i < NPIX; i++) if (seen[i]) n_seen++;
    checks++;
    if (n_disp !== NPIX || n_wr !== NPIX || n_seen !== NPIX) begin
      errors++;
      $display("FAIL frame_counts disp=%0d wr=%0d uniq=%0d want %0d",
               n_disp, n_wr, n_seen, NPIX);
    end
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end done=%0d busy=%b want 1 0",
               n_done, busy);
    end
    checks++;
    if (multi !== 0) begin
      errors++;
      $display("FAIL frame_onehot got %0d want 0", multi);
    end
  endtask

  task automatic test_stall();
    int  lat;
    bit  got;
    do_reset();
    re_min = 32'h12345678;
    im_max = 32'h0;
    step = 32'h100;
    available = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (latch_en) lat++;
    end
    checks++;
    if (lat !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall latches=%0d busy=%b want 0 1", lat, busy);
    end
    available = 8'b0010_0000;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (latch_en) begin
        got = 1;
        checks++;
        if (int'(engine_addr) !== 5 || in_word[82:64] !== '0 ||
            in_word[63:32] !== 32'h12345678) begin
          errors++;
          $display("FAIL stall_release addr=%0d xy=%h want 5 0",
                   engine_addr, in_word[82:64]);
        end
        available = '0;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL stall_timeout latch=%b want 1", got);
    end
  endtask

  task automatic test_round_robin();
    int ord[2];
    int n, multi;
    do_reset();
    service_req = 8'b0000_0010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ack[1]) service_req[1] = 1'b0;
    end
    service_req = 8'b0000_1010;
    n = 0;
    multi = 0;
    ord[0] = -1;
    ord[1] = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ack !== '0 && !$onehot(req_ack)) multi++;
      for (int e = 0; e < N; e++) begin
        if (req_ack[e] && service_req[e]) begin
          if (n < 2) ord[n] = e;
          n++;
          service_req[e] = 1'b0;
        end
      end
    end
    checks++;
    if (ord[0] !== 3 || ord[1] !== 1 || n !== 2) begin
      errors++;
      $display("FAIL rr_order got %0d,%0d n=%0d want 3,1 n=2",
               ord[0], ord[1], n);
    end
    checks++;
    if (multi !== 0) begin
      errors++;
      $display("FAIL rr_onehot got %0d want 0", multi);
    end
  endtask

  task automatic test_hold();
    int          ackc, fbc;
    logic [26:0] pat;
    do_reset();
    pat = {10'd2, 9'd1, 8'h5A};
    service_req = 8'b0100_0000;
    ackc = 0;
    fbc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fb_we) begin
        fbc++;
        checks++;
        if (fb_addr !== 19'd6 || fb_data !== 8'h5A) begin
          errors++;
          $display("FAIL hold_fb got %0d/%h want 6/5a",
                   fb_addr, fb_data);
        end
      end
      if (req_ack[6]) begin
        ackc++;
        out_word = pat;
        if (ackc == 4) service_req[6] = 1'b0;
      end else begin
        out_word = '0;
      end
    end
    checks++;
    if (ackc !== 4) begin
      errors++;
      $display("FAIL hold_ack_cycles got %0d want 4", ackc);
    end
    checks++;
    if (fbc !== 1) begin
      errors++;
      $display("FAIL hold_fb_count got %0d want 1", fbc);
    end
  endtask

  task automatic test_reset_mid();
    int           lat;
    logic [131:0] outs;
    do_reset();
    eng_mask = 8'b0000_0111;
    lat_fix = 60;
    salt = 8'h00;
    engine_reset();
    re_min = 32'hFE000000;
    im_max = 32'h01000000;
    step = 32'h00800000;
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (latch_en) lat++;
      engine_step();
      start = (c == 0);
    end
    start = 1'b0;
    checks++;
    if (lat !== 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_outstanding latches=%0d busy=%b want 3 1",
               lat, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {engine_addr, in_word, latch_en, req_ack, fb_we,
            fb_addr, fb_data, busy, frame_done};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h want 0", outs);
    end
    engine_reset();
    rst = 1'b0;
    lat_fix = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame(8'b0000_0011, 32'hFE000000, 32'h01800000,
               32'h00800000, 8'h00, 1'b1, 6);
    for (int f = 0; f < 3; f++) begin
      test_frame(8'($urandom_range(1, 255)), $urandom, $urandom,
                 $urandom, 8'($urandom), 1'b0, 12);
    end
    test_stall();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_frame(8'hFF, $urandom, $urandom, $urandom,
               8'($urandom), 1'b0, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
